// File: rtl/reprogram_multi_pkg.sv
// Shared types and helpers for the multi-slot lock reprogramming block.
package lock_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ENTER_BUTTON_DEF = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTER_PC  = 3'd1,
    S_ENTER_UC1 = 3'd2,
    S_ENTER_UC2 = 3'd3,
    S_FAIL      = 3'd4,
    S_COMPLETE  = 3'd5,
    S_LOCKOUT   = 3'd6
  } state_e;

  // The enter key is never a digit, even if its value is 0..9.
  function automatic logic is_digit(input logic [DIGIT_W-1:0] b,
                                    input logic [DIGIT_W-1:0] enter);
    return (b <= 4'd9) && (b != enter);
  endfunction

endpackage

// File: rtl/reprogram_multi_collector.sv
// Keypad digit collector shared by the PC, UC1 and UC2 entry steps.
module code_collector
  import lock_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int LW     = $clog2(DIGITS + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic [DIGIT_W-1:0]        BUTTON,
  input  logic                      BPRESS,
  input  logic [DIGIT_W-1:0]        ENTER_BUTTON,
  output logic [DIGIT_W*DIGITS-1:0] DIGITS_OUT,
  output logic [LW-1:0]             COUNT,
  output logic                      BAD,
  output logic                      ENTER_STB
);

  localparam logic [LW-1:0] DIGITS_C = LW'(DIGITS);

  logic [DIGIT_W*DIGITS-1:0] digits_q, digits_d;
  logic [LW-1:0]             count_q, count_d;
  logic                      bad_q, bad_d;

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    bad_d    = bad_q;
    if (CLR) begin
      digits_d = '0;
      count_d  = '0;
      bad_d    = 1'b0;
    end else if (BPRESS && (BUTTON != ENTER_BUTTON)) begin
      if (is_digit(BUTTON, ENTER_BUTTON) && (count_q < DIGITS_C)) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (count_q == LW'(i)) digits_d[DIGIT_W*i +: DIGIT_W] = BUTTON;
        end
        count_d = count_q + LW'(1);
      end else begin
        // Overflow or a non-digit key poisons the entry until the next clear.
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      digits_q <= '0;
      count_q  <= '0;
      bad_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      bad_q    <= bad_d;
    end
  end

  assign DIGITS_OUT = digits_q;
  assign COUNT      = count_q;
  assign BAD        = bad_q;
  assign ENTER_STB  = BPRESS && (BUTTON == ENTER_BUTTON);

endmodule

// File: rtl/reprogram_multi.sv
// Multi-slot user-code reprogramming FSM with entry timeout and PC brute-force lockout.
module reprogram_multi
  import lock_pkg::*;
#(
  parameter int                 DIGITS         = 6,
  parameter int                 MIN_LEN        = 4,
  parameter int                 SLOTS          = 4,
  parameter logic [DIGIT_W-1:0] ENTER_BUTTON   = ENTER_BUTTON_DEF,
  parameter int                 MAX_FAILS      = 3,
  parameter int                 LOCKOUT_CYCLES = 1000,
  parameter int                 TIMEOUT_CYCLES = 5000,
  parameter int                 SW             = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  parameter int                 LW             = $clog2(DIGITS + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      GO,
  input  logic [SW-1:0]             SLOT,
  input  logic [DIGIT_W*DIGITS-1:0] PC,
  input  logic [LW-1:0]             PC_LENGTH,
  input  logic [DIGIT_W-1:0]        BUTTON,
  input  logic                      BPRESS,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      SUCCESS,
  output logic                      WR_EN,
  output logic [SW-1:0]             WR_SLOT,
  output logic [DIGIT_W*DIGITS-1:0] NEWCODE,
  output logic [LW-1:0]             NEWLENGTH,
  output logic                      LOCKED
);

  localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LK_LAST   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAILS_MAX = FW'(MAX_FAILS);
  localparam logic [LW-1:0] MIN_LEN_C = LW'(MIN_LEN);
  localparam logic [LW-1:0] DIGITS_C  = LW'(DIGITS);
  localparam logic [SW:0]   SLOTS_C   = (SW + 1)'(SLOTS);

  state_e                    state_q, state_d;
  logic [FW-1:0]             fails_q, fails_d;
  logic [TW-1:0]             tmr_q, tmr_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic [DIGIT_W*DIGITS-1:0] newcode_q, newcode_d;
  logic [LW-1:0]             newlen_q, newlen_d;

  logic                      clr;
  logic                      in_entry;
  logic                      col_press;
  logic [DIGIT_W*DIGITS-1:0] col_digits;
  logic [LW-1:0]             col_count;
  logic                      col_bad;
  logic                      enter_stb;
  logic                      to_hit;
  logic                      pc_eq;
  logic [DIGIT_W*DIGITS-1:0] uc_masked;

  assign in_entry  = (state_q == S_ENTER_PC) || (state_q == S_ENTER_UC1) ||
                     (state_q == S_ENTER_UC2);
  assign col_press = BPRESS && in_entry;
  // A press in the expiry cycle reloads the timer instead of timing out.
  assign to_hit    = in_entry && !BPRESS && (tmr_q == TO_LAST);

  code_collector #(
    .DIGITS (DIGITS),
    .LW     (LW)
  ) u_collector (
    .CLK          (CLK),
    .RST          (RST),
    .CLR          (clr),
    .BUTTON       (BUTTON),
    .BPRESS       (col_press),
    .ENTER_BUTTON (ENTER_BUTTON),
    .DIGITS_OUT   (col_digits),
    .COUNT        (col_count),
    .BAD          (col_bad),
    .ENTER_STB    (enter_stb)
  );

  always_comb begin
    pc_eq     = 1'b1;
    uc_masked = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (LW'(i) < col_count) begin
        uc_masked[DIGIT_W*i +: DIGIT_W] = col_digits[DIGIT_W*i +: DIGIT_W];
        if (col_digits[DIGIT_W*i +: DIGIT_W] != PC[DIGIT_W*i +: DIGIT_W]) pc_eq = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fails_d   = fails_q;
    slot_d    = slot_q;
    newcode_d = newcode_q;
    newlen_d  = newlen_q;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (GO) begin
          slot_d = SLOT;
          if ({1'b0, SLOT} >= SLOTS_C) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_ENTER_PC;
            clr     = 1'b1;
          end
        end
      end
      S_ENTER_PC: begin
        if (enter_stb) begin
          if (!col_bad && (col_count == PC_LENGTH) && pc_eq) begin
            state_d = S_ENTER_UC1;
            fails_d = '0;
            clr     = 1'b1;
          end else begin
            state_d = S_FAIL;
            fails_d = fails_q + FW'(1);
          end
        end else if (to_hit) begin
          state_d = S_FAIL;
          fails_d = fails_q + FW'(1);
        end
      end
      S_ENTER_UC1: begin
        if (enter_stb) begin
          if (!col_bad && (col_count >= MIN_LEN_C) && (col_count <= DIGITS_C)) begin
            state_d   = S_ENTER_UC2;
            newcode_d = uc_masked;
            newlen_d  = col_count;
            clr       = 1'b1;
          end else begin
            state_d = S_FAIL;
          end
        end else if (to_hit) begin
          state_d = S_FAIL;
        end
      end
      S_ENTER_UC2: begin
        if (enter_stb) begin
          if (!col_bad && (col_count == newlen_q) && (uc_masked == newcode_q)) begin
            state_d = S_COMPLETE;
          end else begin
            state_d = S_FAIL;
          end
        end else if (to_hit) begin
          state_d = S_FAIL;
        end
      end
      S_COMPLETE: state_d = S_IDLE;
      S_FAIL:     state_d = (fails_q == FAILS_MAX) ? S_LOCKOUT : S_IDLE;
      S_LOCKOUT: begin
        if (tmr_q == LK_LAST) begin
          state_d = S_IDLE;
          fails_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One timer serves both the entry timeout and the lockout duration.
  always_comb begin
    tmr_d = tmr_q;
    if ((state_d != state_q) || col_press) begin
      tmr_d = '0;
    end else if (in_entry || (state_q == S_LOCKOUT)) begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      fails_q   <= '0;
      tmr_q     <= '0;
      slot_q    <= '0;
      newcode_q <= '0;
      newlen_q  <= '0;
    end else begin
      state_q   <= state_d;
      fails_q   <= fails_d;
      tmr_q     <= tmr_d;
      slot_q    <= slot_d;
      newcode_q <= newcode_d;
      newlen_q  <= newlen_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_FAIL) || (state_q == S_COMPLETE);
  assign SUCCESS   = (state_q == S_COMPLETE);
  assign WR_EN     = (state_q == S_COMPLETE);
  assign LOCKED    = (state_q == S_LOCKOUT);
  assign WR_SLOT   = slot_q;
  assign NEWCODE   = newcode_q;
  assign NEWLENGTH = newlen_q;

endmodule

// File: tb/tb_reprogram_multi.sv
// Randomized scoreboard bench for reprogram_multi against a session-level reference model.
module tb_reprogram_multi;

  localparam int DIGITS    = 6;
  localparam int MIN_LEN   = 4;
  localparam int SLOTS     = 3;
  localparam int ENTER     = 14;
  localparam int MAX_FAILS = 3;
  localparam int LOCK_C    = 1000;
  localparam int TO_C      = 5000;
  localparam int SW        = 2;
  localparam int LW        = 3;

  logic              CLK = 1'b0;
  logic              RST, GO, BPRESS;
  logic [SW-1:0]     SLOT;
  logic [4*DIGITS-1:0] PC;
  logic [LW-1:0]     PC_LENGTH;
  logic [3:0]        BUTTON;
  logic              BUSY, DONE, SUCCESS, WR_EN, LOCKED;
  logic [SW-1:0]     WR_SLOT;
  logic [4*DIGITS-1:0] NEWCODE;
  logic [LW-1:0]     NEWLENGTH;

  reprogram_multi #(
    .DIGITS(DIGITS), .MIN_LEN(MIN_LEN), .SLOTS(SLOTS), .ENTER_BUTTON(4'(ENTER)),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCK_C), .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .CLK(CLK), .RST(RST), .GO(GO), .SLOT(SLOT), .PC(PC), .PC_LENGTH(PC_LENGTH),
    .BUTTON(BUTTON), .BPRESS(BPRESS), .BUSY(BUSY), .DONE(DONE), .SUCCESS(SUCCESS),
    .WR_EN(WR_EN), .WR_SLOT(WR_SLOT), .NEWCODE(NEWCODE), .NEWLENGTH(NEWLENGTH),
    .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit     succ;
    int     slot;
    int     len;
    longint code;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  int     m_fails = 0;
  int     m_slot  = 0;
  int     m_len   = 0;
  longint m_code  = 0;
  int     m_pc[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void eval(input int seq[$], output int d[$], output bit bad);
    d = {};
    bad = 1'b0;
    foreach (seq[i]) begin
      if (seq[i] > 9) bad = 1'b1;
      else if (d.size() == DIGITS) bad = 1'b1;
      else d.push_back(seq[i]);
    end
  endfunction

  function automatic longint pack(input int d[$]);
    longint r = 0;
    foreach (d[i]) r |= longint'(d[i]) << (4 * i);
    return r;
  endfunction

  function automatic void rand_seq(output int q[$], input int len, input bit allow_bad);
    int b;
    q = {};
    for (int i = 0; i < len; i++) begin
      b = int'($urandom_range(0, 9));
      if (allow_bad && ($urandom_range(0, 11) == 0)) begin
        b = 10 + int'($urandom_range(0, 4));
        if (b == ENTER) b = 15;
      end
      q.push_back(b);
    end
  endfunction

  // Monitor: pop one expectation for every end-of-session pulse.
  exp_t mon_e;
  always @(posedge CLK) begin
    #1;
    if ((DONE === 1'b1) || (WR_EN === 1'b1)) begin
      check("wr_en_vs_done", WR_EN, DONE && SUCCESS);
      if (sbq.size() == 0) begin
        check("unexpected_done", DONE, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("success", SUCCESS, mon_e.succ);
        check("wr_en", WR_EN, mon_e.succ);
        check("wr_slot", WR_SLOT, mon_e.slot);
        check("newlength", NEWLENGTH, mon_e.len);
        check("newcode", NEWCODE, mon_e.code);
      end
    end
  end

  task automatic push_exp(input bit succ);
    exp_t e;
    e.succ = succ; e.slot = m_slot; e.len = m_len; e.code = m_code;
    sbq.push_back(e);
  endtask

  task automatic set_pc(input int q[$]);
    @(negedge CLK);
    m_pc = q;
    PC = '0;
    foreach (q[i]) PC[4*i +: 4] = 4'(q[i]);
    PC_LENGTH = LW'(q.size());
  endtask

  task automatic go(input int s);
    @(negedge CLK);
    GO = 1'b1;
    SLOT = SW'(s);
    @(negedge CLK);
    GO = 1'b0;
    SLOT = SW'($urandom_range(0, 3));
  endtask

  task automatic press(input int b, input int gap);
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    BUTTON = 4'(b);
    BPRESS = 1'b1;
    @(negedge CLK);
    BPRESS = 1'b0;
    BUTTON = 4'($urandom_range(0, 15));
  endtask

  task automatic press_seq(input int seq[$]);
    foreach (seq[i]) press(seq[i], int'($urandom_range(0, 2)));
  endtask

  task automatic finish_session(input bit succ, input bit immediate, input bit is_to);
    int waited = 0;
    int n;
    bit lk;
    if (immediate) check("done_latency", DONE, 1);
    while (!DONE && (waited < TO_C + 100)) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (is_to) check("timeout_cycles", waited, TO_C);
    check("done_seen", DONE, 1);
    lk = !succ && (m_fails == MAX_FAILS);
    @(posedge CLK); #1;
    check("done_one_cycle", DONE, 0);
    check("locked", LOCKED, lk);
    check("busy_after_done", BUSY, lk);
    if (lk) begin
      n = 1;
      while (n < LOCK_C + 20) begin
        @(posedge CLK); #1;
        GO = (n == LOCK_C / 2);
        SLOT = '0;
        if (!LOCKED) break;
        n++;
      end
      GO = 1'b0;
      check("lockout_len", n, LOCK_C);
      check("busy_at_lock_exit", BUSY, 0);
      @(posedge CLK); #1;
      check("go_in_lockout_ignored", BUSY, 0);
      m_fails = 0;
    end
  endtask

  // to_stage: 0 none, 1 timeout in PC entry, 2 in UC1, 3 in UC2
  task automatic session(input int s, input int pcs[$], input int uc1[$], input int uc2[$],
                         input int to_stage);
    int d[$];
    bit bad;
    bit ok;
    m_slot = s;
    if (s >= SLOTS) begin
      push_exp(1'b0);
      go(s);
      finish_session(1'b0, 1'b1, 1'b0);
      return;
    end
    go(s);
    check("busy_after_go", BUSY, 1);
    if (to_stage == 1) begin
      m_fails++;
      push_exp(1'b0);
      finish_session(1'b0, 1'b0, 1'b1);
      return;
    end
    press_seq(pcs);
    eval(pcs, d, bad);
    ok = !bad && (d.size() == m_pc.size());
    if (ok) foreach (d[i]) if (d[i] != m_pc[i]) ok = 1'b0;
    if (!ok) begin
      m_fails++;
      push_exp(1'b0);
      press(ENTER, 0);
      finish_session(1'b0, 1'b1, 1'b0);
      return;
    end
    m_fails = 0;
    press(ENTER, 0);
    if (to_stage == 2) begin
      push_exp(1'b0);
      finish_session(1'b0, 1'b0, 1'b1);
      return;
    end
    press_seq(uc1);
    eval(uc1, d, bad);
    if (bad || (d.size() < MIN_LEN)) begin
      push_exp(1'b0);
      press(ENTER, 0);
      finish_session(1'b0, 1'b1, 1'b0);
      return;
    end
    m_len = d.size();
    m_code = pack(d);
    press(ENTER, 0);
    if (to_stage == 3) begin
      push_exp(1'b0);
      finish_session(1'b0, 1'b0, 1'b1);
      return;
    end
    press_seq(uc2);
    eval(uc2, d, bad);
    ok = !bad && (d.size() == m_len) && (pack(d) == m_code);
    push_exp(ok);
    press(ENTER, 0);
    finish_session(ok, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_wr_en"}, WR_EN, 0);
    check({tag, "_locked"}, LOCKED, 0);
    check({tag, "_newcode"}, NEWCODE, 0);
    check({tag, "_newlength"}, NEWLENGTH, 0);
    check({tag, "_wr_slot"}, WR_SLOT, 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs(tag);
    @(negedge CLK);
    RST = 1'b0;
    m_fails = 0; m_slot = 0; m_len = 0; m_code = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc1[$], good[$], bad_pc[$], uc5[$], uc3[$], uc7[$], uc4[$], empty[$];
    int rp[$], ra[$], rb[$];
    RST = 1'b1; GO = 1'b0; SLOT = '0; PC = '0; PC_LENGTH = '0; BUTTON = '0; BPRESS = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    check("reset_success", SUCCESS, 0);
    @(negedge CLK);
    RST = 1'b0;

    pc1    = {1, 2, 3, 4};
    bad_pc = {1, 2, 3, 5};
    uc5    = {5, 6, 7, 8, 9};
    uc3    = {5, 6, 7};
    uc7    = {1, 2, 3, 4, 5, 6, 7};
    uc4    = {5, 6, 7, 8};
    empty  = {};
    set_pc(pc1);

    // Happy path
    session(2, pc1, uc5, uc5, 0);
    check("happy_newcode", NEWCODE, 24'h098765);
    check("happy_newlength", NEWLENGTH, 5);
    check("happy_wr_slot", WR_SLOT, 2);

    // Three wrong PCs trigger lockout
    repeat (3) session(0, bad_pc, empty, empty, 0);

    // Invalid new codes
    session(1, pc1, uc3, empty, 0);
    session(1, pc1, uc7, empty, 0);
    session(1, pc1, uc5, uc4, 0);

    // Timeouts, counter clearing and out-of-range slot
    session(0, empty, empty, empty, 1);
    session(1, pc1, uc4, uc4, 0);
    session(0, bad_pc, empty, empty, 0);
    session(0, bad_pc, empty, empty, 0);
    session(3, empty, empty, empty, 0);
    session(0, pc1, empty, empty, 2);
    session(0, bad_pc, empty, empty, 0);
    session(0, bad_pc, empty, empty, 0);

    // Reset in PC entry clears the fail counter
    go(1);
    press(1, 0);
    apply_reset("rst_pc");
    session(0, bad_pc, empty, empty, 0);
    session(0, bad_pc, empty, empty, 0);

    // Reset in UC2 entry aborts with no write
    m_slot = 1;
    go(1);
    press_seq(pc1); press(ENTER, 0);
    press_seq(uc5); press(ENTER, 0);
    press(5, 0); press(6, 1);
    apply_reset("rst_uc2");

    // Randomized sessions
    set_pc(pc1);
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        rand_seq(rp, int'($urandom_range(1, 6)), 1'b0);
        set_pc(rp);
      end
      if ($urandom_range(0, 9) < 7) ra = m_pc;
      else rand_seq(ra, int'($urandom_range(1, 6)), 1'b1);
      rand_seq(rb, int'($urandom_range(3, 7)), 1'b1);
      if ($urandom_range(0, 9) < 7) ra = ra;
      session(int'($urandom_range(0, 3)), ra, rb,
              ($urandom_range(0, 9) < 7) ? rb : rp, 0);
    end

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
